// File: rtl/fixed_point_divider.sv
// ---------------------------------------------------------------------------
// fixed_point_divider
//
// Sequential restoring divider. An unsigned DIVIDEND_W-bit integer is divided
// by an unsigned DIVISOR_W-bit integer. The result is an unsigned fixed-point
// quotient with DIVIDEND_W integer bits and FRAC_W fraction bits. One quotient
// bit is produced per clock, MSB first. One extra guard bit is computed so the
// result can optionally be rounded up by half an LSB.
//
// Ports
//   Clk       in   1            clock, rising edge
//   Reset     in   1            asynchronous, active-low reset
//   Start     in   1            request; only looked at in IDLE or DONE
//   Dividend  in   DIVIDEND_W   operand, captured when Start is accepted
//   Divisor   in   DIVISOR_W    operand, captured when Start is accepted
//   Quotient  out  Q_W          floor(Dividend*2^FRAC_W / Divisor) (+guard)
//   DivZero   out  1            result came from a zero divisor
//   Busy      out  1            high while the divide is running or rounding
//   Ack       out  1            level; high in DONE until the next accepted Start
// ---------------------------------------------------------------------------
module fixed_point_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int FRAC_W     = 8,
    parameter bit ROUND_EN   = 1'b0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [DIVIDEND_W-1:0]        Dividend,
    input  logic [DIVISOR_W-1:0]         Divisor,
    output logic [DIVIDEND_W+FRAC_W-1:0] Quotient,
    output logic                         DivZero,
    output logic                         Busy,
    output logic                         Ack
);

    localparam int Q_W   = DIVIDEND_W + FRAC_W;
    localparam int CNT_W = $clog2(Q_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ROUND,
        S_DONE
    } state_t;

    state_t               state_q;
    // Holds the extended dividend {Dividend, FRAC_W+1 zeros}. Each RUN cycle
    // its MSB is consumed and the new quotient bit enters at the LSB. After
    // Q_W+1 cycles it holds the full quotient, including the guard bit in bit 0.
    logic [Q_W:0]         shift_q;
    logic [DIVISOR_W:0]   rem_q;
    logic [DIVISOR_W-1:0] divisor_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [Q_W-1:0]       quot_q;
    logic                 divzero_q;
    logic                 busy_q;
    logic                 ack_q;

    logic [DIVISOR_W:0]   trial_d;
    logic                 qbit_d;
    logic [DIVISOR_W:0]   rem_d;

    // The remainder is always below the divisor, so it fits in DIVISOR_W bits.
    // Shifting one more bit in therefore needs only DIVISOR_W+1 bits and cannot
    // overflow.
    assign trial_d = {rem_q[DIVISOR_W-1:0], shift_q[Q_W]};
    assign qbit_d  = (trial_d >= {1'b0, divisor_q});
    assign rem_d   = qbit_d ? (trial_d - {1'b0, divisor_q}) : trial_d;

    // Drop the guard bit. When rounding is enabled, add the guard bit back in
    // as a half-LSB round-up. A carry out of the top bit saturates to all ones.
    function automatic logic [Q_W-1:0] round_sat(input logic [Q_W:0] q);
        logic [Q_W:0] sum;
        sum = {1'b0, q[Q_W:1]} + {{Q_W{1'b0}}, (ROUND_EN ? q[0] : 1'b0)};
        if (sum[Q_W]) begin
            return '1;
        end
        return sum[Q_W-1:0];
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        divisor_q <= Divisor;
                        shift_q   <= {Dividend, {(FRAC_W + 1){1'b0}}};
                        rem_q     <= '0;
                        if (Divisor == '0) begin
                            // Zero divisor: skip the divide and report right away.
                            quot_q    <= '1;
                            divzero_q <= 1'b1;
                            ack_q     <= 1'b1;
                            busy_q    <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= S_DONE;
                        end else begin
                            divzero_q <= 1'b0;
                            ack_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            cnt_q     <= CNT_W'(Q_W + 1);
                            state_q   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    shift_q <= {shift_q[Q_W-1:0], qbit_d};
                    rem_q   <= rem_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    quot_q  <= round_sat(shift_q);
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Quotient = quot_q;
    assign DivZero  = divzero_q;
    assign Busy     = busy_q;
    assign Ack      = ack_q;

endmodule
